// File: rtl/pe_pkg.sv
// Shared types and default sizes for the output-stationary MAC PE.
package pe_pkg;
    typedef enum logic {PE_IDLE = 1'b0, PE_ACCUM = 1'b1} pe_state_e;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int K_MAX_DEF  = 256;
endpackage

// File: rtl/pe_mac_acc.sv
// Combinational multiply / extend / accumulate step of the PE.
// PE_OS_MAC_SATURATE_EN selects clamping instead of modular wrap.
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    input  logic [ACC_W-1:0]  acc,
    input  logic              sgn,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] a_s, w_s, prod_s;
    logic [PW-1:0]        prod_u;
    logic [ACC_W-1:0]     prod_x;

    assign a_s    = PW'($signed(a));
    assign w_s    = PW'($signed(w));
    assign prod_s = a_s * w_s;
    assign prod_u = PW'(a) * PW'(w);
    assign prod_x = sgn ? ACC_W'(prod_s) : ACC_W'(prod_u);

`ifdef PE_OS_MAC_SATURATE_EN
    logic [ACC_W:0] sum_w;

    always_comb begin
        sum_w = sgn ? ({acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x})
                    : ({1'b0, acc} + {1'b0, prod_x});
        sum = sum_w[ACC_W-1:0];
        sat = 1'b0;
        // Signed overflow shows as disagreement between the guard bit and the MSB.
        if (sgn && (sum_w[ACC_W] != sum_w[ACC_W-1])) begin
            sat = 1'b1;
            sum = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else if (!sgn && sum_w[ACC_W]) begin
            sat = 1'b1;
            sum = '1;
        end
    end
`else
    assign sum = acc + prod_x;
    assign sat = 1'b0;
`endif
endmodule

// File: rtl/pe_os_mac.sv
// Output-stationary systolic MAC PE: operand forwarding, tile FSM and result handshake.
// Optional clamping arithmetic via PE_OS_MAC_SATURATE_EN.
module pe_os_mac
    import pe_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  ACC_W  = ACC_W_DEF,
    parameter int  K_MAX  = K_MAX_DEF,
    localparam int CNT_W  = $clog2(K_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] w_out,
    output logic              w_valid_out,
    input  logic [CNT_W-1:0]  k_len,
    input  logic              signed_mode,
    input  logic              clear,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid,
    input  logic              psum_ready,
    output logic              psum_sat,
    output logic              busy,
    output logic              err_overrun
);
    if (ACC_W < 2 * DATA_W) begin : g_width_chk
        $error("pe_os_mac: ACC_W must be >= 2*DATA_W");
    end

    pe_state_e        state;
    logic [CNT_W-1:0] cnt, cnt_nxt, len_q, len_eff;
    logic [ACC_W-1:0] acc, acc_in, step_sum;
    logic             sgn_q, sgn_sel, sat_q, step_sat, tile_sat;
    logic             pair, complete, idle;

    assign idle    = (state == PE_IDLE);
    assign pair    = a_valid_in && w_valid_in;
    assign cnt_nxt = cnt + 1'b1;
    assign busy    = (state == PE_ACCUM);

    always_comb begin
        len_eff = k_len;
        if (k_len == '0)
            len_eff = CNT_W'(1);
        else if (k_len > CNT_W'(K_MAX))
            len_eff = CNT_W'(K_MAX);
    end

    // The first pair of a tile starts from zero using the live mode input.
    assign acc_in   = idle ? '0 : acc;
    assign sgn_sel  = idle ? signed_mode : sgn_q;
    assign complete = pair && !clear && (idle ? (len_eff == CNT_W'(1)) : (cnt_nxt == len_q));
    assign tile_sat = (sat_q && !idle) || step_sat;

    pe_mac_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .a   (a_in),
        .w   (w_in),
        .acc (acc_in),
        .sgn (sgn_sel),
        .sum (step_sum),
        .sat (step_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            w_out       <= '0;
            w_valid_out <= 1'b0;
        end else begin
            a_valid_out <= a_valid_in;
            w_valid_out <= w_valid_in;
            if (a_valid_in) a_out <= a_in;
            if (w_valid_in) w_out <= w_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PE_IDLE;
            cnt   <= '0;
            acc   <= '0;
            len_q <= '0;
            sgn_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (clear || complete) begin
            state <= PE_IDLE;
            cnt   <= '0;
            acc   <= '0;
            sat_q <= 1'b0;
        end else if (pair) begin
            state <= PE_ACCUM;
            acc   <= step_sum;
            sat_q <= tile_sat;
            cnt   <= idle ? CNT_W'(1) : cnt_nxt;
            if (idle) begin
                len_q <= len_eff;
                sgn_q <= signed_mode;
            end
        end
    end

    // A completing tile may reuse the slot on the same edge it is consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psum_out    <= '0;
            psum_valid  <= 1'b0;
            psum_sat    <= 1'b0;
            err_overrun <= 1'b0;
        end else if (complete) begin
            if (!psum_valid || psum_ready) begin
                psum_out   <= step_sum;
                psum_sat   <= tile_sat;
                psum_valid <= 1'b1;
            end else begin
                err_overrun <= 1'b1;
            end
        end else if (psum_ready) begin
            psum_valid <= 1'b0;
        end
    end
endmodule
